inst_encode_loader: RTL and testbench

- Inverse of the instruction decoder.
- Accepts decoded instruction fields over a valid/ready handshake: class, 4-bit ALU op code, destination bit, bit number.
- Encodes them into the 8-bit instruction word format the decoder consumes.
- Writes each word into program memory at an auto-incrementing address.
- Used by the boot/test loader to fill program memory ahead of execution.

---
 rtl/inst_encode_loader_if.sv | 27 ++
 rtl/inst_encode_loader.sv | 187 ++++++++++++++++++
 tb/tb_inst_encode_loader.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/inst_encode_loader_if.sv
// rtl/inst_encode_loader_if.sv - decoded-instruction field handshake into the encode loader
interface inst_encode_loader_if;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] op_class;
    logic [3:0] alu_op;
    logic       d;
    logic [2:0] bit_number;

    modport master (
        output in_valid,
        output op_class,
        output alu_op,
        output d,
        output bit_number,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  op_class,
        input  alu_op,
        input  d,
        input  bit_number,
        output in_ready
    );
endinterface

// File: rtl/inst_encode_loader.sv
// rtl/inst_encode_loader.sv - encodes decoded fields into 8-bit words and fills program memory
// Optional INST_ENC_READBACK_EN: adds a VERIFY read-back cycle after every write.
module inst_encode_loader #(
    parameter int ADDR_W = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    inst_encode_loader_if.slave in_if,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [7:0]          mem_wdata,
    output logic [ADDR_W:0]     count,
    output logic                full,
    output logic                err,
    output logic                err_sticky
`ifdef INST_ENC_READBACK_EN
    ,
    output logic                mem_re,
    input  logic [7:0]          mem_rdata,
    output logic                verify_fail
`endif
);

    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   COUNT_ONE = (ADDR_W + 1)'(1);

    typedef enum logic [2:0] {
        IDLE,
        ENCODE,
        WRITE,
`ifdef INST_ENC_READBACK_EN
        VERIFY,
`endif
        FULL
    } state_t;

    state_t      state, state_d;
    logic        started;
    logic [1:0]  cls_q;
    logic [3:0]  op_q;
    logic        d_q;
    logic [2:0]  bn_q;
    logic        accept;
    logic        enc_ok;
    logic [7:0]  enc_word;
    logic [3:0]  f;
    logic [1:0]  s;

    // started keeps in_ready low until the first edge after reset release
    assign in_if.in_ready = (state == IDLE) && !full && started;
    assign accept         = in_if.in_valid && in_if.in_ready;
    assign mem_we         = (state == WRITE);
    assign err            = (state == ENCODE) && !enc_ok;
`ifdef INST_ENC_READBACK_EN
    assign mem_re         = (state == VERIFY);
`endif

    always_comb begin
        enc_ok   = 1'b1;
        f        = 4'h0;
        s        = 2'b00;
        enc_word = 8'h00;
        case (cls_q)
            2'b00: begin
                case (op_q)
                    4'd0:    f = 4'b1000;
                    4'd1:    f = 4'b0000;
                    4'd2:    f = 4'b0111;
                    4'd3:    f = 4'b0010;
                    4'd4:    f = 4'b0101;
                    4'd5:    f = 4'b1010;
                    4'd6:    f = 4'b0011;
                    4'd7:    f = 4'b0110;
                    4'd9:    f = 4'b0001;
                    4'd10:   f = 4'b0100;
                    4'd11:   f = 4'b1110;
                    4'd12:   f = 4'b1001;
                    default: enc_ok = 1'b0;
                endcase
                enc_word = {2'b00, f, d_q, 1'b0};
            end
            2'b01: begin
                case (op_q)
                    4'd13:   s = 2'b00;
                    4'd14:   s = 2'b01;
                    default: enc_ok = 1'b0;
                endcase
                enc_word = {2'b01, s, bn_q, 1'b0};
            end
            2'b11: begin
                case (op_q)
                    4'd0:    f = 4'b0000;
                    4'd10:   f = 4'b1000;
                    4'd4:    f = 4'b1001;
                    4'd7:    f = 4'b1010;
                    4'd3:    f = 4'b1100;
                    4'd2:    f = 4'b1110;
                    default: enc_ok = 1'b0;
                endcase
                enc_word = {2'b11, f, 2'b00};
            end
            default: enc_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (accept) state_d = ENCODE;
            ENCODE:  state_d = enc_ok ? WRITE : IDLE;
`ifdef INST_ENC_READBACK_EN
            WRITE:   state_d = VERIFY;
            VERIFY:  state_d = (mem_addr == ADDR_LAST) ? FULL : IDLE;
`else
            WRITE:   state_d = (mem_addr == ADDR_LAST) ? FULL : IDLE;
`endif
            FULL:    state_d = FULL;
            default: state_d = IDLE;
        endcase
        if (clear) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            started    <= 1'b0;
            cls_q      <= 2'b00;
            op_q       <= 4'h0;
            d_q        <= 1'b0;
            bn_q       <= 3'h0;
            mem_addr   <= '0;
            mem_wdata  <= 8'h00;
            count      <= '0;
            full       <= 1'b0;
            err_sticky <= 1'b0;
`ifdef INST_ENC_READBACK_EN
            verify_fail <= 1'b0;
`endif
        end else begin
            state   <= state_d;
            started <= 1'b1;
            if (clear) begin
                mem_addr   <= '0;
                count      <= '0;
                full       <= 1'b0;
                err_sticky <= 1'b0;
`ifdef INST_ENC_READBACK_EN
                verify_fail <= 1'b0;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        if (accept) begin
                            cls_q <= in_if.op_class;
                            op_q  <= in_if.alu_op;
                            d_q   <= in_if.d;
                            bn_q  <= in_if.bit_number;
                        end
                    end
                    ENCODE: begin
                        // rejected words leave mem_wdata holding the last written value
                        if (enc_ok) mem_wdata  <= enc_word;
                        else        err_sticky <= 1'b1;
                    end
                    WRITE: begin
                        count <= count + COUNT_ONE;
`ifndef INST_ENC_READBACK_EN
                        if (mem_addr == ADDR_LAST) full <= 1'b1;
                        else                       mem_addr <= mem_addr + ADDR_ONE;
`endif
                    end
`ifdef INST_ENC_READBACK_EN
                    VERIFY: begin
                        if (mem_rdata != mem_wdata) verify_fail <= 1'b1;
                        if (mem_addr == ADDR_LAST) full <= 1'b1;
                        else                       mem_addr <= mem_addr + ADDR_ONE;
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_inst_encode_loader.sv
// tb/tb_inst_encode_loader.sv - directed and random checks of inst_encode_loader against a field-level model
module tb_inst_encode_loader;
    localparam int AW    = 2;
    localparam int DEPTH = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;
    always #5 clk = ~clk;

    inst_encode_loader_if bus ();

    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic [AW:0]   count;
    logic          full;
    logic          err;
    logic          err_sticky;
`ifdef INST_ENC_READBACK_EN
    logic          mem_re;
    logic [7:0]    mem_rdata;
    logic          verify_fail;
    logic          rd_corrupt = 1'b0;
    logic [7:0]    mem [0:DEPTH-1];
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
    assign mem_rdata = rd_corrupt ? ~mem[mem_addr] : mem[mem_addr];
`endif

    inst_encode_loader #(.ADDR_W(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .in_if      (bus),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .count      (count),
        .full       (full),
        .err        (err),
        .err_sticky (err_sticky)
`ifdef INST_ENC_READBACK_EN
        ,
        .mem_re     (mem_re),
        .mem_rdata  (mem_rdata),
        .verify_fail(verify_fail)
`endif
    );

    int checks = 0;
    int errors = 0;
    int m_addr = 0;
    int m_count = 0;
    int m_full = 0;
    int m_sticky = 0;
    int m_vfail = 0;

    // f code per alu_op, -1 where the op has no encoding in that class
    int byte_f [16] = '{8, 0, 7, 2, 5, 10, 3, 6, -1, 1, 4, 14, 9, -1, -1, -1};
    int lit_f  [16] = '{0, -1, 14, 12, 9, -1, -1, 10, -1, -1, 8, -1, -1, -1, -1, -1};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int enc_model(input int cls, input int op, input int dd, input int bn);
        case (cls)
            0: return (byte_f[op] < 0) ? -1 : 64 * 0 + byte_f[op] * 4 + dd * 2;
            1: return (op == 13) ? 64 + bn * 2 : (op == 14) ? 80 + bn * 2 : -1;
            3: return (lit_f[op] < 0) ? -1 : 192 + lit_f[op] * 4;
            default: return -1;
        endcase
    endfunction

    function automatic void dec_model(input int w, output int op, output int dd, output int bn);
        int cls = w / 64;
        op = -1; dd = (w / 2) % 2; bn = (w / 2) % 8;
        if (cls == 0) begin
            for (int i = 0; i < 16; i++) if (byte_f[i] == (w / 4) % 16) op = i;
        end else if (cls == 1) begin
            if ((w / 16) % 4 == 0) op = 13;
            else if ((w / 16) % 4 == 1) op = 14;
        end else if (cls == 3) begin
            for (int i = 0; i < 16; i++) if (lit_f[i] == (w / 4) % 16) op = i;
        end
    endfunction

    task automatic issue(input int cls, input int op, input int dd, input int bn, input string tag);
        int w, lim, rop, rd, rbn;
        w = enc_model(cls, op, dd, bn);
        @(negedge clk);
        bus.in_valid   = 1'b1;
        bus.op_class   = cls[1:0];
        bus.alu_op     = op[3:0];
        bus.d          = dd[0];
        bus.bit_number = bn[2:0];
        lim = 0;
        while (!bus.in_ready && lim < 20) begin @(negedge clk); lim++; end
        check({tag, " ready"}, bus.in_ready, 1);
        @(posedge clk); #1 bus.in_valid = 1'b0;
        @(negedge clk);
        check({tag, " enc_we"}, mem_we, 0);
        check({tag, " err"}, err, (w < 0) ? 1 : 0);
        check({tag, " enc_ready"}, bus.in_ready, 0);
        @(negedge clk);
        if (w >= 0) begin
            check({tag, " we"}, mem_we, 1);
            check({tag, " addr"}, mem_addr, m_addr);
            check({tag, " wdata"}, mem_wdata, w);
            dec_model(int'(mem_wdata), rop, rd, rbn);
            check({tag, " rt_op"}, rop, op);
            if (cls == 0) check({tag, " rt_d"}, rd, dd);
            if (cls == 1) check({tag, " rt_bn"}, rbn, bn);
            m_count++;
            if (m_addr == DEPTH - 1) m_full = 1; else m_addr++;
`ifdef INST_ENC_READBACK_EN
            if (rd_corrupt) m_vfail = 1;
`endif
        end else begin
            check({tag, " no_we"}, mem_we, 0);
            m_sticky = 1;
        end
        @(negedge clk);
        check({tag, " count"}, count, m_count);
        @(negedge clk);
        check({tag, " addr_after"}, mem_addr, m_addr);
        check({tag, " full"}, full, m_full);
        check({tag, " sticky"}, err_sticky, m_sticky);
`ifdef INST_ENC_READBACK_EN
        check({tag, " vfail"}, verify_fail, m_vfail);
`endif
    endtask

    task automatic do_clear(input string tag);
        @(negedge clk); clear = 1'b1;
        @(posedge clk); #1 clear = 1'b0;
        m_addr = 0; m_count = 0; m_full = 0; m_sticky = 0; m_vfail = 0;
        @(negedge clk);
        check({tag, " clr_addr"}, mem_addr, 0);
        check({tag, " clr_full"}, full, 0);
        check({tag, " clr_count"}, count, 0);
        check({tag, " clr_sticky"}, err_sticky, 0);
        check({tag, " clr_ready"}, bus.in_ready, 1);
`ifdef INST_ENC_READBACK_EN
        check({tag, " clr_vfail"}, verify_fail, 0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        bus.in_valid = 1'b0; bus.op_class = 2'b00; bus.alu_op = 4'h0; bus.d = 1'b0; bus.bit_number = 3'h0;
        repeat (3) @(negedge clk);
        check("rst ready", bus.in_ready, 0);
        check("rst we", mem_we, 0);
        check("rst addr", mem_addr, 0);
        check("rst wdata", mem_wdata, 0);
        check("rst count", count, 0);
        check("rst full", full, 0);
        check("rst err", err, 0);
        check("rst sticky", err_sticky, 0);
        rst_n = 1'b1;
        #1 check("rel ready0", bus.in_ready, 0);
        @(negedge clk);
        check("rel ready1", bus.in_ready, 1);

        issue(0, 2, 1, 0, "byte2");
        issue(1, 14, 0, 5, "bsf5");
        issue(1, 13, 1, 0, "bcf0");
        issue(0, 8, 0, 0, "byte8_bad");
        issue(2, 0, 0, 0, "cls10_bad");
        issue(3, 10, 1, 7, "lit10");

        check("full flag", full, 1);
        check("full ready", bus.in_ready, 0);
        @(negedge clk);
        bus.in_valid = 1'b1; bus.op_class = 2'b00; bus.alu_op = 4'd1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("full no_we", mem_we, 0);
        end
        bus.in_valid = 1'b0;
        check("full count", count, 4);
        check("full addr", mem_addr, 3);
        do_clear("after_full");

        issue(0, 15, 0, 0, "byte15_bad");
        @(negedge clk);
        bus.in_valid = 1'b1; bus.op_class = 2'b00; bus.alu_op = 4'd0; bus.d = 1'b1;
        @(posedge clk); #1 bus.in_valid = 1'b0;
        @(negedge clk); clear = 1'b1;
        @(posedge clk); #1 clear = 1'b0;
        m_addr = 0; m_count = 0; m_full = 0; m_sticky = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("enc_clear no_we", mem_we, 0);
        end
        check("enc_clear count", count, 0);
        check("enc_clear sticky", err_sticky, 0);
        check("enc_clear addr", mem_addr, 0);

`ifdef INST_ENC_READBACK_EN
        rd_corrupt = 1'b1;
        issue(3, 4, 0, 0, "rb_corrupt");
        rd_corrupt = 1'b0;
        issue(0, 5, 0, 0, "rb_clean");
        do_clear("after_rb");
`endif

        for (int n = 0; n < 24; n++) begin
            if (m_full != 0) begin
                check("rnd full_ready", bus.in_ready, 0);
                do_clear("rnd");
            end
            issue($urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 1),
                  $urandom_range(0, 7), "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
